// File: rtl/avalon_rr_arbiter_pkg.sv
// Shared definitions for the round-robin Avalon-MM arbiter: default widths,
// master-id sizing helper and the grant-lock state encoding.
package avalon_rr_arbiter_pkg;

  localparam int DEF_NUM_MASTERS     = 2;
  localparam int DEF_AW              = 32;
  localparam int DEF_DW              = 32;
  localparam int DEF_MAX_OUTSTANDING = 4;

  // Width of an index into n items; never below one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [id_width(DEF_NUM_MASTERS)-1:0] master_id_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/avalon_rr_arbiter_tag_fifo.sv
// Synchronous tag FIFO recording which master issued each outstanding read;
// head is visible combinationally so returns can be routed with zero latency.
module avalon_arb_tag_fifo
  import avalon_rr_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUTSTANDING,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = id_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  // A single-entry FIFO must keep its pointers pinned at zero.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (DEPTH == 1) return '0;
    return p + 1'b1;
  endfunction

  // Fullness comes from the registered count, so a same-cycle pop never frees a slot.
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/avalon_rr_arbiter.sv
// N-master to 1-slave Avalon-MM arbiter: round-robin grant, locked while the
// slave stalls, with read returns steered back through a tag FIFO.
module avalon_rr_arbiter
  import avalon_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS     = DEF_NUM_MASTERS,
  parameter int AW              = DEF_AW,
  parameter int DW              = DEF_DW,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*AW-1:0]     m_address,
  input  logic [NUM_MASTERS*DW-1:0]     m_writedata,
  input  logic [NUM_MASTERS*(DW/8)-1:0] m_byteenable,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DW-1:0]                 m_readdata,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic                          s_read,
  output logic                          s_write,
  output logic [AW-1:0]                 s_address,
  output logic [DW-1:0]                 s_writedata,
  output logic [DW/8-1:0]               s_byteenable,
  input  logic                          s_waitrequest,
  input  logic [DW-1:0]                 s_readdata,
  input  logic                          s_readdatavalid,
  output logic                          err_unexpected_rdv
);

  localparam int IDW = id_width(NUM_MASTERS);
  localparam int BEW = DW / 8;

  typedef logic [IDW-1:0] id_t;

  arb_state_t state_reg, state_next;
  id_t        rr_ptr_reg, rr_ptr_next;
  id_t        lock_id_reg, lock_id_next;
  logic       err_reg;

  logic [NUM_MASTERS-1:0] eligible;
  logic [AW-1:0]          addr_arr [NUM_MASTERS];
  logic [DW-1:0]          wdata_arr [NUM_MASTERS];
  logic [BEW-1:0]         be_arr [NUM_MASTERS];

  logic scan_valid;
  id_t  scan_grant;
  logic grant_valid;
  id_t  grant;
  logic cmd_valid;
  logic issue;

  logic fifo_full, fifo_empty, fifo_push, fifo_pop;
  id_t  fifo_head;

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign eligible[gi]  = m_write[gi] || (m_read[gi] && !fifo_full);
      assign addr_arr[gi]  = m_address[gi*AW +: AW];
      assign wdata_arr[gi] = m_writedata[gi*DW +: DW];
      assign be_arr[gi]    = m_byteenable[gi*BEW +: BEW];
      assign m_waitrequest[gi] =
          (grant_valid && (grant == id_t'(gi))) ? s_waitrequest : 1'b1;
      assign m_readdatavalid[gi] = fifo_pop && (fifo_head == id_t'(gi));
    end
  endgenerate

  // Scan from rr_ptr upward; iterating in reverse lets the nearest eligible master win.
  always_comb begin
    int idx;
    scan_valid = 1'b0;
    scan_grant = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_MASTERS) begin
        idx = idx - NUM_MASTERS;
      end
      if (eligible[idx]) begin
        scan_valid = 1'b1;
        scan_grant = id_t'(idx);
      end
    end
  end

  always_comb begin
    grant_valid = scan_valid;
    grant       = scan_grant;
    if (state_reg == ARB_LOCKED) begin
      grant_valid = 1'b1;
      grant       = lock_id_reg;
    end
  end

  // A locked read can never be full: nothing is pushed while the lock is held.
  assign s_read       = grant_valid && m_read[grant] && !fifo_full;
  assign s_write      = grant_valid && m_write[grant];
  assign s_address    = addr_arr[grant];
  assign s_writedata  = wdata_arr[grant];
  assign s_byteenable = be_arr[grant];
  assign m_readdata   = s_readdata;

  assign cmd_valid = s_read || s_write;
  assign issue     = cmd_valid && !s_waitrequest;
  assign fifo_push = issue && s_read;
  assign fifo_pop  = s_readdatavalid && !fifo_empty;

  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    lock_id_next = lock_id_reg;
    if (issue) begin
      state_next  = ARB_OPEN;
      rr_ptr_next = (grant == id_t'(NUM_MASTERS - 1)) ? '0 : id_t'(grant + 1'b1);
    end else if (cmd_valid) begin
      state_next   = ARB_LOCKED;
      lock_id_next = grant;
    end else begin
      // Also releases a lock whose master dropped its request.
      state_next = ARB_OPEN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ARB_OPEN;
      rr_ptr_reg  <= '0;
      lock_id_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      lock_id_reg <= lock_id_next;
      if (s_readdatavalid && fifo_empty) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err_unexpected_rdv = err_reg;

  avalon_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (grant),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// Directed bench: a 2-master arbiter for arbitration/lock/FIFO behaviour and a
// 3-master arbiter for pointer wrap and routing to a non-zero master.
module tb_avalon_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Two-master instance
  logic [1:0]  a_m_read = '0, a_m_write = '0;
  logic [63:0] a_m_address = '0, a_m_writedata = '0;
  logic [7:0]  a_m_byteenable = '0;
  logic [1:0]  a_m_waitrequest, a_m_readdatavalid;
  logic [31:0] a_m_readdata;
  logic        a_s_read, a_s_write;
  logic [31:0] a_s_address, a_s_writedata;
  logic [3:0]  a_s_byteenable;
  logic        a_s_waitrequest = 1'b0;
  logic [31:0] a_s_readdata = '0;
  logic        a_s_readdatavalid = 1'b0;
  logic        a_err;

  // Three-master instance
  logic [2:0]  b_m_read = '0, b_m_write = '0;
  logic [95:0] b_m_address = '0, b_m_writedata = '0;
  logic [11:0] b_m_byteenable = '0;
  logic [2:0]  b_m_waitrequest, b_m_readdatavalid;
  logic [31:0] b_m_readdata;
  logic        b_s_read, b_s_write;
  logic [31:0] b_s_address, b_s_writedata;
  logic [3:0]  b_s_byteenable;
  logic        b_s_waitrequest = 1'b0;
  logic [31:0] b_s_readdata = '0;
  logic        b_s_readdatavalid = 1'b0;
  logic        b_err;

  avalon_rr_arbiter #(.NUM_MASTERS(2), .AW(32), .DW(32), .MAX_OUTSTANDING(4)) dut_a (
    .clk(clk), .rst(rst),
    .m_read(a_m_read), .m_write(a_m_write), .m_address(a_m_address),
    .m_writedata(a_m_writedata), .m_byteenable(a_m_byteenable),
    .m_waitrequest(a_m_waitrequest), .m_readdata(a_m_readdata),
    .m_readdatavalid(a_m_readdatavalid),
    .s_read(a_s_read), .s_write(a_s_write), .s_address(a_s_address),
    .s_writedata(a_s_writedata), .s_byteenable(a_s_byteenable),
    .s_waitrequest(a_s_waitrequest), .s_readdata(a_s_readdata),
    .s_readdatavalid(a_s_readdatavalid), .err_unexpected_rdv(a_err)
  );

  avalon_rr_arbiter #(.NUM_MASTERS(3), .AW(32), .DW(32), .MAX_OUTSTANDING(4)) dut_b (
    .clk(clk), .rst(rst),
    .m_read(b_m_read), .m_write(b_m_write), .m_address(b_m_address),
    .m_writedata(b_m_writedata), .m_byteenable(b_m_byteenable),
    .m_waitrequest(b_m_waitrequest), .m_readdata(b_m_readdata),
    .m_readdatavalid(b_m_readdatavalid),
    .s_read(b_s_read), .s_write(b_s_write), .s_address(b_s_address),
    .s_writedata(b_s_writedata), .s_byteenable(b_s_byteenable),
    .s_waitrequest(b_s_waitrequest), .s_readdata(b_s_readdata),
    .s_readdatavalid(b_s_readdatavalid), .err_unexpected_rdv(b_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs are then changed and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("idle_s_read", 64'(a_s_read), 64'(1'b0));
    check("idle_s_write", 64'(a_s_write), 64'(1'b0));
    check("idle_wait", 64'(a_m_waitrequest), 64'(2'b11));
    check("idle_rdv", 64'(a_m_readdatavalid), 64'(2'b00));
    check("idle_err", 64'(a_err), 64'(1'b0));
    check("idle_b_wait", 64'(b_m_waitrequest), 64'(3'b111));

    // Both masters read every cycle; returns two cycles after issue
    a_m_address = {32'h0000_0020, 32'h0000_0010};
    for (int k = 0; k < 6; k++) begin
      a_m_read          = (k < 4) ? 2'b11 : 2'b00;
      a_s_readdatavalid = (k >= 2);
      a_s_readdata      = 32'hA000_0000 + 32'(k);
      #1;
      if (k < 4) begin
        check($sformatf("rr_addr%0d", k), 64'(a_s_address),
              64'((k % 2 != 0) ? 32'h20 : 32'h10));
        check($sformatf("rr_wait%0d", k), 64'(a_m_waitrequest),
              64'((k % 2 != 0) ? 2'b01 : 2'b10));
      end
      if (k >= 2) begin
        check($sformatf("rr_rdv%0d", k), 64'(a_m_readdatavalid),
              64'((k % 2 == 0) ? 2'b01 : 2'b10));
        check($sformatf("rr_rdata%0d", k), 64'(a_m_readdata), 64'(32'hA000_0000 + 32'(k)));
      end
      tick();
    end
    a_s_readdatavalid = 1'b0;

    // Master 0 write alone moves rr_ptr to 1
    a_m_write   = 2'b01;
    a_m_address = {32'h0, 32'h0000_0040};
    #1;
    check("w0_s_write", 64'(a_s_write), 64'(1'b1));
    check("w0_wait", 64'(a_m_waitrequest), 64'(2'b10));
    tick();

    // Master 1 write stalled three cycles while master 0 waits
    a_m_write      = 2'b11;
    a_m_address    = {32'h0000_0100, 32'h0000_0200};
    a_m_writedata  = {32'hDEAD_BEEF, 32'h1234_5678};
    a_m_byteenable = 8'hF3;
    for (int c = 1; c <= 5; c++) begin
      a_s_waitrequest = (c <= 3);
      if (c == 5) a_m_write = 2'b01;
      #1;
      check($sformatf("stall_addr%0d", c), 64'(a_s_address),
            64'((c <= 4) ? 32'h100 : 32'h200));
      check($sformatf("stall_wdata%0d", c), 64'(a_s_writedata),
            64'((c <= 4) ? 32'hDEAD_BEEF : 32'h1234_5678));
      check($sformatf("stall_wait%0d", c), 64'(a_m_waitrequest),
            64'((c <= 3) ? 2'b11 : ((c == 4) ? 2'b01 : 2'b10)));
      tick();
    end
    check("stall_be", 64'(a_m_byteenable[7:4]), 64'(4'hF));
    a_m_write = 2'b00;

    // Lock holds master 1 even when rr_ptr favours master 0
    a_m_write       = 2'b10;
    a_m_address     = {32'h0000_0300, 32'h0000_0400};
    a_s_waitrequest = 1'b0;
    #1;
    check("lk_pre_addr", 64'(a_s_address), 64'(32'h300));
    tick();
    a_s_waitrequest = 1'b1;
    #1;
    check("lk_a_addr", 64'(a_s_address), 64'(32'h300));
    tick();
    a_m_write = 2'b11;
    #1;
    check("lk_b_addr", 64'(a_s_address), 64'(32'h300));
    check("lk_b_wait", 64'(a_m_waitrequest), 64'(2'b11));
    tick();
    a_s_waitrequest = 1'b0;
    #1;
    check("lk_c_addr", 64'(a_s_address), 64'(32'h300));
    check("lk_c_wait", 64'(a_m_waitrequest), 64'(2'b01));
    tick();
    a_m_write = 2'b01;
    #1;
    check("lk_d_addr", 64'(a_s_address), 64'(32'h400));
    check("lk_d_wait", 64'(a_m_waitrequest), 64'(2'b10));
    tick();

    // Locked master drops its request: slave sees nothing, lock clears next cycle
    a_m_write       = 2'b10;
    a_m_address     = {32'h0000_0600, 32'h0000_0700};
    a_s_waitrequest = 1'b1;
    #1;
    check("drop_e_addr", 64'(a_s_address), 64'(32'h600));
    tick();
    a_m_write = 2'b01;
    #1;
    check("drop_f_s_write", 64'(a_s_write), 64'(1'b0));
    check("drop_f_wait", 64'(a_m_waitrequest), 64'(2'b11));
    tick();
    a_s_waitrequest = 1'b0;
    #1;
    check("drop_g_s_write", 64'(a_s_write), 64'(1'b1));
    check("drop_g_addr", 64'(a_s_address), 64'(32'h700));
    tick();
    a_m_write = 2'b00;

    // Fill the tag FIFO with four reads from master 0
    a_m_read    = 2'b01;
    a_m_address = {32'h0000_0900, 32'h0000_0800};
    for (int r = 0; r < 4; r++) begin
      #1;
      check($sformatf("fill_s_read%0d", r), 64'(a_s_read), 64'(1'b1));
      check($sformatf("fill_wait%0d", r), 64'(a_m_waitrequest), 64'(2'b10));
      tick();
    end
    // Fifth read masked while a write from master 1 goes through
    a_m_write = 2'b10;
    #1;
    check("full_s_read", 64'(a_s_read), 64'(1'b0));
    check("full_s_write", 64'(a_s_write), 64'(1'b1));
    check("full_addr", 64'(a_s_address), 64'(32'h900));
    check("full_wait", 64'(a_m_waitrequest), 64'(2'b01));
    tick();
    a_m_write         = 2'b00;
    a_s_readdatavalid = 1'b1;
    #1;
    check("full_pop_rdv", 64'(a_m_readdatavalid), 64'(2'b01));
    check("full_pop_s_read", 64'(a_s_read), 64'(1'b0));
    check("full_pop_wait", 64'(a_m_waitrequest), 64'(2'b11));
    tick();
    a_s_readdatavalid = 1'b0;
    #1;
    check("refill_s_read", 64'(a_s_read), 64'(1'b1));
    check("refill_addr", 64'(a_s_address), 64'(32'h800));
    check("refill_wait", 64'(a_m_waitrequest), 64'(2'b10));
    tick();
    a_m_read = 2'b00;
    a_s_readdatavalid = 1'b1;
    for (int d = 0; d < 4; d++) begin
      #1;
      check($sformatf("drain_rdv%0d", d), 64'(a_m_readdatavalid), 64'(2'b01));
      tick();
    end

    // Stray readdatavalid with nothing outstanding
    #1;
    check("stray_rdv", 64'(a_m_readdatavalid), 64'(2'b00));
    check("stray_err_pre", 64'(a_err), 64'(1'b0));
    tick();
    a_s_readdatavalid = 1'b0;
    for (int h = 0; h < 3; h++) begin
      #1;
      check($sformatf("stray_err_hold%0d", h), 64'(a_err), 64'(1'b1));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_err_clr", 64'(a_err), 64'(1'b0));
    check("rst_wait", 64'(a_m_waitrequest), 64'(2'b11));

    // Three masters: only master 2 requesting with rr_ptr at 0
    b_m_write   = 3'b100;
    b_m_address = {32'h0000_0C00, 32'h0000_0B00, 32'h0000_0A00};
    #1;
    check("n3_m2_s_write", 64'(b_s_write), 64'(1'b1));
    check("n3_m2_addr", 64'(b_s_address), 64'(32'hC00));
    check("n3_m2_wait", 64'(b_m_waitrequest), 64'(3'b011));
    tick();
    b_m_write = 3'b011;
    #1;
    check("n3_wrap_addr", 64'(b_s_address), 64'(32'hA00));
    check("n3_wrap_wait", 64'(b_m_waitrequest), 64'(3'b110));
    tick();
    b_m_write = 3'b000;
    b_m_read  = 3'b100;
    #1;
    check("n3_read", 64'(b_s_read), 64'(1'b1));
    tick();
    b_m_read          = 3'b000;
    b_s_readdatavalid = 1'b1;
    b_s_readdata      = 32'h5555_AAAA;
    #1;
    check("n3_rdv", 64'(b_m_readdatavalid), 64'(3'b100));
    check("n3_rdata", 64'(b_m_readdata), 64'(32'h5555_AAAA));
    tick();
    b_s_readdatavalid = 1'b0;
    #1;
    check("n3_err", 64'(b_err), 64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
